// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the multi-cycle EX-stage ALU.
// Both the control unit and the ALU import these definitions.
package alu_pkg;

    localparam logic [2:0] ADD_OP = 3'b000;
    localparam logic [2:0] SUB_OP = 3'b001;
    localparam logic [2:0] AND_OP = 3'b010;
    localparam logic [2:0] OR_OP  = 3'b011;
    localparam logic [2:0] MUL_OP = 3'b101;
    localparam logic [2:0] DIV_OP = 3'b110;
    localparam logic [2:0] REM_OP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_iter_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// done_o pulses once quotient_o/remainder_o hold the final result.
module alu_iter_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
    logic [WIDTH:0]   partial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;

    // The first iteration runs in the load cycle straight from the inputs,
    // so the final bit lands one cycle earlier and the caller sees WIDTH+1.
    always_comb begin
        rem_src  = start_i ? '0         : rem_q;
        quo_src  = start_i ? dividend_i : quo_q;
        dvs_src  = start_i ? divisor_i  : dvs_q;
        partial  = {rem_src, quo_src[WIDTH-1]};
        fits     = (partial >= {1'b0, dvs_src});
        rem_step = fits ? (partial[WIDTH-1:0] - dvs_src) : partial[WIDTH-1:0];
        quo_step = {quo_src[WIDTH-2:0], fits};
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start_i) begin
            rem_d    = rem_step;
            quo_d    = quo_step;
            dvs_d    = divisor_i;
            cnt_d    = CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle ADD/SUB/AND/OR plus iterative MUL/DIV/REM,
// with a start/busy/done handshake the hazard unit uses to stall the pipe.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             Overflow_o
);

    localparam int unsigned      MSB       = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, alu_res, acc_next;
    logic             alu_ovf;
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    alu_iter_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (data1_i),
        .divisor_i   (data2_i),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        sum     = data1_i + data2_i;
        diff    = data1_i - data2_i;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl_i)
            ADD_OP: begin
                alu_res = sum;
                alu_ovf = (data1_i[MSB] == data2_i[MSB]) && (sum[MSB] != data1_i[MSB]);
            end
            SUB_OP: begin
                alu_res = diff;
                alu_ovf = (data1_i[MSB] != data2_i[MSB]) && (diff[MSB] != data1_i[MSB]);
            end
            AND_OP:  alu_res = data1_i & data2_i;
            OR_OP:   alu_res = data1_i | data2_i;
            default: alu_res = '0;
        endcase
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d = ALUCtrl_i;
                    case (ALUCtrl_i)
                        MUL_OP: begin
                            mcand_d  = data1_i;
                            mplier_d = data2_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = ST_MUL;
                        end
                        DIV_OP, REM_OP: begin
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                        default: begin
                            data_d  = alu_res;
                            zero_d  = (alu_res == '0);
                            ovf_d   = alu_ovf;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    data_d  = acc_next;
                    zero_d  = (acc_next == '0);
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    data_d  = (op_q == REM_OP) ? div_rem : div_quo;
                    zero_d  = (((op_q == REM_OP) ? div_rem : div_quo) == '0);
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign data_o     = data_q;
    assign Zero_o     = zero_q;
    assign Overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32: handshake timing, results,
// flags, divide-by-zero, busy-time input blocking and asynchronous reset.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero, ovf;
    logic [31:0] data;

    int total = 0;
    int bad   = 0;
    int lat;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ALUCtrl_i  (op),
        .data1_i    (a),
        .data2_i    (b),
        .busy_o     (busy),
        .done_o     (done),
        .data_o     (data),
        .Zero_o     (zero),
        .Overflow_o (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for the accept cycle; returns one cycle after accept.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_d,
                          input logic exp_z, input logic exp_o, input int exp_lat);
        issue(o, x, y);
        wait_done();
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/done"}, done, 1'b1);
        check({tag, "/busy"}, busy, 1'b1);
        check({tag, "/data"}, data, exp_d);
        check({tag, "/zero"}, zero, exp_z);
        check({tag, "/ovf"}, ovf, exp_o);
        tick();
        check({tag, "/done_drop"}, done, 1'b0);
        check({tag, "/idle"}, busy, 1'b0);
        check({tag, "/hold"}, data, exp_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = ADD_OP;
        a     = '0;
        b     = '0;
        #1;
        check("reset/busy", busy, 1'b0);
        check("reset/done", done, 1'b0);
        check("reset/data", data, 32'h0);
        check("reset/zero", zero, 1'b0);
        check("reset/ovf", ovf, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle/busy", busy, 1'b0);

        run_op("sub_zero", SUB_OP, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1);
        run_op("add_wrap", ADD_OP, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 1);
        run_op("and", AND_OP, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1);
        run_op("or", OR_OP, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1);
        run_op("sub_ovf", SUB_OP, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        run_op("add_ovf", ADD_OP, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1);

        // Reset in the middle of a multiply must clear everything at once.
        issue(MUL_OP, 32'd7, 32'd9);
        repeat (9) tick();
        check("mid_mul/busy", busy, 1'b1);
        check("mid_mul/done", done, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst/busy", busy, 1'b0);
        check("async_rst/done", done, 1'b0);
        check("async_rst/data", data, 32'h0);
        check("async_rst/zero", zero, 1'b0);
        check("async_rst/ovf", ovf, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst/busy", busy, 1'b0);
        run_op("add_after_rst", ADD_OP, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);

        run_op("mul_hi_discard", MUL_OP, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 33);
        run_op("mul_123x456", MUL_OP, 32'd123, 32'd456, 32'd56088, 1'b0, 1'b0, 33);
        run_op("div_100_7", DIV_OP, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
        run_op("rem_100_7", REM_OP, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
        run_op("div_by_zero", DIV_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        run_op("rem_by_zero", REM_OP, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0, 33);

        // Requests toggled during a divide must be ignored.
        issue(DIV_OP, 32'd100, 32'd7);
        op  = ADD_OP;
        a   = 32'd1;
        b   = 32'd1;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            check("busy_hold/busy", busy, 1'b1);
            start = ~start;
            tick();
            lat++;
        end
        start = 1'b0;
        check("busy_div/latency", 64'(lat), 64'd33);
        check("busy_div/data", data, 32'd14);
        tick();
        check("busy_div/single_pulse", done, 1'b0);
        check("busy_div/idle", busy, 1'b0);
        run_op("back_to_back_add", ADD_OP, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

        run_op("reserved_op", 3'b100, 32'd3, 32'd4, 32'h0, 1'b1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
